// File: rtl/eaglesong_bit_matrix_step.sv
// Sequential GF(2) bit-matrix mixing stage of the Eaglesong round: one matrix bit per cycle.
// Optional abort input is enabled by defining EAGLESONG_BM_ABORT_EN.
module eaglesong_bit_matrix_step (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [511:0] state_in,
`ifdef EAGLESONG_BM_ABORT_EN
    input  logic         abort,
`endif
    input  logic         requested_bit,
    output logic         busy,
    output logic         done,
    output logic [511:0] state_out,
    output logic [7:0]   bit_index_to_request
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]   state;
    logic [511:0] latched;
    logic [511:0] acc;
    logic [511:0] acc_next;
    logic [31:0]  source_word;
    logic [3:0]   word_j;
    logic [3:0]   word_k;
    logic         abort_req;

`ifdef EAGLESONG_BM_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // The requested index doubles as the loop counter: high nibble picks the source word, low nibble the target word.
    assign word_k = bit_index_to_request[7:4];
    assign word_j = bit_index_to_request[3:0];
    assign busy   = (state == RUN);

    always_comb begin
        source_word = '0;
        for (int w = 0; w < 16; w++) begin
            if (word_k == w[3:0]) begin
                source_word = latched[32*w +: 32];
            end
        end
    end

    always_comb begin
        acc_next = acc;
        for (int w = 0; w < 16; w++) begin
            if (requested_bit && (word_j == w[3:0])) begin
                acc_next[32*w +: 32] = acc[32*w +: 32] ^ source_word;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            latched              <= '0;
            acc                  <= '0;
            state_out            <= '0;
            done                 <= 1'b0;
            bit_index_to_request <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        latched              <= state_in;
                        acc                  <= '0;
                        bit_index_to_request <= '0;
                        state                <= RUN;
                    end
                end
                RUN: begin
                    if (abort_req) begin
                        bit_index_to_request <= '0;
                        state                <= IDLE;
                    end else begin
                        acc                  <= acc_next;
                        bit_index_to_request <= bit_index_to_request + 8'd1;
                        // The last index folds its own term straight into the published result.
                        if (bit_index_to_request == 8'd255) begin
                            state_out <= acc_next;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eaglesong_bit_matrix_step.sv
// Self-checking bench for eaglesong_bit_matrix_step: models the constant matrix and the mixing function.
// Abort checks are compiled in when EAGLESONG_BM_ABORT_EN is defined.
module tb_eaglesong_bit_matrix_step;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [511:0] state_in;
    logic         requested_bit;
    logic         busy;
    logic         done;
    logic [511:0] state_out;
    logic [7:0]   bit_index_to_request;
`ifdef EAGLESONG_BM_ABORT_EN
    logic         abort;
`endif

    int checks;
    int fails;

    // Matrix model: each row k is row 0 rotated by k, so bit j of row k is row0[(j-k) mod 16].
    localparam logic [15:0] ROW0 = 16'h8FAF;
    logic [255:0] matrix;

    typedef struct {
        string        name;
        logic [511:0] stim;
        logic [511:0] expected;
    } vector_t;

    vector_t vectors[8];

    eaglesong_bit_matrix_step dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .start                (start),
        .state_in             (state_in),
`ifdef EAGLESONG_BM_ABORT_EN
        .abort                (abort),
`endif
        .requested_bit        (requested_bit),
        .busy                 (busy),
        .done                 (done),
        .state_out            (state_out),
        .bit_index_to_request (bit_index_to_request)
    );

    assign requested_bit = matrix[bit_index_to_request];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] ref_mix(input logic [511:0] in_state);
        logic [511:0] result;
        result = '0;
        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 16; k++) begin
                if (matrix[16*k + j]) begin
                    result[32*j +: 32] = result[32*j +: 32] ^ in_state[32*k +: 32];
                end
            end
        end
        return result;
    endfunction

    function automatic logic [511:0] expand(input logic [15:0] mask, input logic [31:0] word);
        logic [511:0] result;
        result = '0;
        for (int j = 0; j < 16; j++) begin
            if (mask[j]) result[32*j +: 32] = word;
        end
        return result;
    endfunction

    task automatic check_output(input string name, input logic [511:0] actual, input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
    task automatic apply_stimulus(input logic [511:0] stim);
        state_in = stim;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Returns at the negedge where done is high (or after the cycle budget expires).
    task automatic wait_done(input string name, input logic [511:0] expected,
                             input int interfere_at, input logic [511:0] interfere_stim);
        int  cycles;
        int  expected_idx;
        logic idx_ok;
        cycles       = 0;
        expected_idx = 0;
        idx_ok       = (bit_index_to_request === 8'd0) && (busy === 1'b1) && (done === 1'b0);
        while (done !== 1'b1 && cycles < 300) begin
            @(negedge clk);
            cycles++;
            if (cycles == interfere_at) begin
                start    = 1'b1;
                state_in = interfere_stim;
            end else if (cycles == interfere_at + 1) begin
                start    = 1'b0;
            end
            if (done !== 1'b1) begin
                expected_idx++;
                if (bit_index_to_request !== expected_idx[7:0] || busy !== 1'b1) idx_ok = 1'b0;
            end
        end
        check_output({name, " latency"}, 512'(cycles), 512'(256));
        check_output({name, " index sweep"}, {511'd0, idx_ok}, 512'd1);
        check_output({name, " busy at done"}, {511'd0, busy}, 512'd0);
        check_output({name, " state_out"}, state_out, expected);
    endtask

    initial begin
        logic [511:0] job_a;
        logic [511:0] job_b;
        logic [511:0] held;
        logic         seen_done;

        checks = 0;
        fails  = 0;
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 16; j++) begin
                matrix[16*k + j] = ROW0[(j - k + 16) % 16];
            end
        end

        vectors[0] = '{"word0 ones", {480'd0, 32'hFFFFFFFF}, expand(16'h8FAF, 32'hFFFFFFFF)};
        vectors[1] = '{"word15 a5", {32'hA5A5A5A5, 480'd0}, expand(16'hC7D7, 32'hA5A5A5A5)};
        vectors[2] = '{"all zero", 512'd0, 512'd0};
        vectors[3] = '{"word0+word15", {32'hA5A5A5A5, 448'd0, 32'hFFFFFFFF},
                       expand(16'h8FAF, 32'hFFFFFFFF) ^ expand(16'hC7D7, 32'hA5A5A5A5)};
        for (int v = 4; v < 8; v++) begin
            logic [511:0] r;
            for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom;
            vectors[v] = '{$sformatf("random%0d", v), r, ref_mix(r)};
        end

        reset_n  = 1'b0;
        start    = 1'b0;
        state_in = '0;
`ifdef EAGLESONG_BM_ABORT_EN
        abort    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_output("reset busy", {511'd0, busy}, 512'd0);
        check_output("reset done", {511'd0, done}, 512'd0);
        check_output("reset state_out", state_out, 512'd0);
        check_output("reset index", {504'd0, bit_index_to_request}, 512'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            apply_stimulus(vectors[v].stim);
            wait_done(vectors[v].name, vectors[v].expected, -10, '0);
            check_output({vectors[v].name, " model"}, state_out, ref_mix(vectors[v].stim));
            @(negedge clk);
            check_output({vectors[v].name, " done pulse"}, {511'd0, done}, 512'd0);
            check_output({vectors[v].name, " held"}, state_out, vectors[v].expected);
        end

        // Start during RUN is ignored, then start in the done cycle launches back-to-back.
        for (int w = 0; w < 16; w++) begin
            job_a[32*w +: 32] = $urandom;
            job_b[32*w +: 32] = $urandom;
        end
        apply_stimulus(job_a);
        wait_done("ignored start", ref_mix(job_a), 100, job_b);
        apply_stimulus(job_b);
        wait_done("back to back", ref_mix(job_b), -10, '0);
        @(negedge clk);

        // Reset mid-run clears everything immediately and cancels the job.
        apply_stimulus(job_a);
        repeat (50) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_output("midrun reset busy", {511'd0, busy}, 512'd0);
        check_output("midrun reset done", {511'd0, done}, 512'd0);
        check_output("midrun reset state_out", state_out, 512'd0);
        check_output("midrun reset index", {504'd0, bit_index_to_request}, 512'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        seen_done = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check_output("no done after reset", {511'd0, seen_done}, 512'd0);

`ifdef EAGLESONG_BM_ABORT_EN
        apply_stimulus(job_b);
        wait_done("pre abort", ref_mix(job_b), -10, '0);
        held = state_out;
        @(negedge clk);
        apply_stimulus(job_a);
        while (bit_index_to_request !== 8'd50 && busy === 1'b1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("abort busy", {511'd0, busy}, 512'd0);
        check_output("abort index", {504'd0, bit_index_to_request}, 512'd0);
        seen_done = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check_output("abort no done", {511'd0, seen_done}, 512'd0);
        check_output("abort state_out held", state_out, held);
`else
        held = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
